// File: rtl/keyframe_interpolator.sv
// keyframe_interpolator: on each frame request walks every channel and writes a hold/step/linear
// interpolated value between the start and target keyframes into the frame buffer.
module keyframe_interpolator #(
  parameter int C_LEDBOARDS = 30,
  parameter int C_CHANNELS  = C_LEDBOARDS * 32,
  parameter int C_ADDR_W    = $clog2(C_CHANNELS),
  parameter int C_BPC       = 12,
  parameter int C_MAX_TIME  = 1024,
  parameter int C_TIME_W    = $clog2(C_MAX_TIME)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_drq,
  input  logic [1:0]          i_mode,
  input  logic [C_TIME_W-1:0] i_start_time,
  input  logic [C_TIME_W-1:0] i_target_time,
  output logic [C_ADDR_W-1:0] o_rd_addr,
  input  logic [C_BPC-1:0]    i_start_data,
  input  logic [C_BPC-1:0]    i_target_data,
  output logic                o_wen,
  output logic [C_ADDR_W-1:0] o_addr,
  output logic [C_BPC-1:0]    o_data,
  output logic                o_busy,
  output logic                o_done,
  output logic [C_TIME_W-1:0] o_time
);

  localparam int C_P_W   = C_BPC + C_TIME_W;
  localparam int C_CNT_W = $clog2(C_P_W + 1);
  localparam logic [C_ADDR_W-1:0] C_LAST     = C_ADDR_W'(C_CHANNELS - 1);
  localparam logic [C_CNT_W-1:0]  C_DIV_LAST = C_CNT_W'(C_P_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_MUL   = 3'd3,
    S_DIV   = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t              state_r, state_s;
  logic [1:0]          mode_r;
  logic [C_TIME_W-1:0] time_r, e_r, d_r, rem_r;
  logic [C_BPC-1:0]    start_r, target_r, mag_r, data_r;
  logic                neg_r, wen_r, busy_r, done_r;
  logic [C_P_W-1:0]    dvd_r;
  logic [C_CNT_W-1:0]  cnt_r;
  logic [C_ADDR_W-1:0] rd_addr_r, addr_r;

  logic [C_TIME_W-1:0] time_inc_s, rem_nx_s;
  logic                e_ge_d_s, bypass_s, ge_s, wr_go_s;
  logic [C_BPC-1:0]    bypass_val_s, quot_s, lin_val_s, wr_val_s;
  logic [C_P_W-1:0]    prod_s, dvd_nx_s;
  logic [C_TIME_W:0]   rem_sh_s;

  assign time_inc_s = time_r + C_TIME_W'(1);
  assign e_ge_d_s   = (e_r >= d_r);
  assign prod_s     = {{C_TIME_W{1'b0}}, mag_r} * {{C_BPC{1'b0}}, e_r};

  // Restoring divider step; the true remainder is below d, so the low bits of the subtraction suffice.
  assign rem_sh_s  = {rem_r, dvd_r[C_P_W-1]};
  assign ge_s      = rem_sh_s[C_TIME_W] | (rem_sh_s[C_TIME_W-1:0] >= d_r);
  assign rem_nx_s  = ge_s ? (rem_sh_s[C_TIME_W-1:0] - d_r) : rem_sh_s[C_TIME_W-1:0];
  assign dvd_nx_s  = {dvd_r[C_P_W-2:0], ge_s};
  assign quot_s    = dvd_nx_s[C_BPC-1:0];
  assign lin_val_s = neg_r ? (start_r - quot_s) : (start_r + quot_s);

  // Mode decode: everything except an in-progress linear ramp resolves without dividing.
  always_comb begin
    bypass_s     = 1'b1;
    bypass_val_s = start_r;
    case (mode_r)
      2'd0: begin
        bypass_s     = 1'b1;
        bypass_val_s = start_r;
      end
      2'd1: begin
        bypass_s     = 1'b1;
        bypass_val_s = e_ge_d_s ? target_r : start_r;
      end
      default: begin
        bypass_s     = (d_r == {C_TIME_W{1'b0}}) || e_ge_d_s;
        bypass_val_s = target_r;
      end
    endcase
  end

  // Write launch: from MUL on bypass, or on the final divider step.
  always_comb begin
    wr_go_s  = 1'b0;
    wr_val_s = bypass_val_s;
    if (state_r == S_MUL && bypass_s) begin
      wr_go_s  = 1'b1;
      wr_val_s = bypass_val_s;
    end else if (state_r == S_DIV && cnt_r == C_DIV_LAST) begin
      wr_go_s  = 1'b1;
      wr_val_s = lin_val_s;
    end else begin
      wr_go_s  = 1'b0;
      wr_val_s = bypass_val_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  state_s = i_drq ? S_READ : S_IDLE;
      S_READ:  state_s = S_LATCH;
      S_LATCH: state_s = S_MUL;
      S_MUL:   state_s = bypass_s ? S_WRITE : S_DIV;
      S_DIV:   state_s = wr_go_s ? S_WRITE : S_DIV;
      S_WRITE: state_s = (addr_r == C_LAST) ? S_DONE : S_READ;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_r    <= 2'd0;
      time_r    <= {C_TIME_W{1'b0}};
      e_r       <= {C_TIME_W{1'b0}};
      d_r       <= {C_TIME_W{1'b0}};
      rem_r     <= {C_TIME_W{1'b0}};
      start_r   <= {C_BPC{1'b0}};
      target_r  <= {C_BPC{1'b0}};
      mag_r     <= {C_BPC{1'b0}};
      neg_r     <= 1'b0;
      dvd_r     <= {C_P_W{1'b0}};
      cnt_r     <= {C_CNT_W{1'b0}};
      rd_addr_r <= {C_ADDR_W{1'b0}};
      addr_r    <= {C_ADDR_W{1'b0}};
      data_r    <= {C_BPC{1'b0}};
      wen_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      wen_r  <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (i_drq) begin
            time_r    <= time_inc_s;
            mode_r    <= i_mode;
            e_r       <= time_inc_s - i_start_time;
            d_r       <= i_target_time - i_start_time;
            rd_addr_r <= {C_ADDR_W{1'b0}};
            busy_r    <= 1'b1;
          end
        end
        S_LATCH: begin
          start_r  <= i_start_data;
          target_r <= i_target_data;
          neg_r    <= (i_target_data < i_start_data);
          mag_r    <= (i_target_data < i_start_data) ? (i_start_data - i_target_data)
                                                     : (i_target_data - i_start_data);
        end
        S_MUL: begin
          dvd_r <= prod_s;
          rem_r <= {C_TIME_W{1'b0}};
          cnt_r <= {C_CNT_W{1'b0}};
        end
        S_DIV: begin
          dvd_r <= dvd_nx_s;
          rem_r <= rem_nx_s;
          cnt_r <= cnt_r + C_CNT_W'(1);
        end
        S_WRITE: begin
          if (addr_r == C_LAST) begin
            done_r <= 1'b1;
          end
        end
        S_DONE: busy_r <= 1'b0;
        default: begin
        end
      endcase
      if (wr_go_s) begin
        wen_r  <= 1'b1;
        addr_r <= rd_addr_r;
        data_r <= wr_val_s;
        if (rd_addr_r != C_LAST) begin
          rd_addr_r <= rd_addr_r + C_ADDR_W'(1);
        end
      end
    end
  end

  assign o_rd_addr = rd_addr_r;
  assign o_wen     = wen_r;
  assign o_addr    = addr_r;
  assign o_data    = data_r;
  assign o_busy    = busy_r;
  assign o_done    = done_r;
  assign o_time    = time_r;

endmodule
